cordic_gain_comp: RTL and testbench
===================================

CORDIC_GAIN_COMP -- requirements
Module: cordic_gain_comp

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: data width of x/y/z, two's complement, Q16.16.
- REQ-002 SHALL have parameter FRAC, default 16: fractional bits; also the number of multiply iterations.
- REQ-003 SHALL have parameter K_CONST, default 39797: CORDIC gain reciprocal 0.607253 in unsigned Q0.FRAC.
- REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-006 SHALL have port in_valid, input, 1: upstream CORDIC result available.
- REQ-007 SHALL have port in_ready, output, 1: block can accept a sample.
- REQ-008 SHALL have ports x_in, y_in, z_in, input, WIDTH: uncompensated CORDIC outputs x, y, z.
- REQ-009 SHALL have port out_valid, output, 1: compensated result held on the outputs.
- REQ-010 SHALL have port out_ready, input, 1: downstream consumer accepts the result.
- REQ-011 SHALL have ports x_out, y_out, z_out, output, WIDTH: compensated x and y; z registered pass-through.
- REQ-012 SHALL have port busy, output, 1: high in MUL state.

Function
- REQ-013 SHALL implement FSM states IDLE, MUL and DONE.
- REQ-014 Transitions SHALL be:
  - IDLE->MUL on in_valid&&in_ready.
  - MUL->DONE after exactly FRAC cycles in MUL.
  - DONE->IDLE on out_ready.
- REQ-015 in_ready SHALL equal (state==IDLE); no input is accepted in MUL or DONE.
- REQ-016 On accept, SHALL capture x_in, y_in and z_in; later input changes SHALL have no effect on the sample in flight.
- REQ-017 SHALL compute x_out=(x_in*K_CONST)>>>FRAC and y_out=(y_in*K_CONST)>>>FRAC as signed products.
- REQ-018 The multiply SHALL be sequential shift-add, one K_CONST bit per cycle, LSB first, with x and y in parallel.
- REQ-019 The accumulator SHALL be WIDTH+FRAC bits wide; no intermediate overflow SHALL occur for any WIDTH-bit input.
- REQ-020 Latency from accept edge to out_valid high SHALL be FRAC+1 cycles (17 at default).
- REQ-021 out_valid SHALL equal (state==DONE).
- REQ-022 x_out, y_out and z_out SHALL hold stable while out_valid is high and out_ready is low.
- REQ-023 DONE with out_ready high SHALL return to IDLE the next cycle; in_valid is sampled only in IDLE, so there is one bubble cycle per sample.
- REQ-024 Outputs SHALL retain the last result after DONE->IDLE until the next DONE.
- REQ-025 Throughput SHALL be at most one sample per FRAC+2 cycles.
- REQ-026 in_valid held high continuously SHALL yield back-to-back samples, each accepted in IDLE.

Reset
- REQ-027 rst_n low SHALL immediately force state IDLE, clear all outputs and the accumulator to 0, set in_ready=1 and out_valid=0, and set busy=0.
- REQ-028 Reset asserted in MUL or DONE SHALL discard the sample in flight; no out_valid pulse SHALL follow.
- REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
- REQ-030 Macro CORDIC_GAIN_ROUND_EN defined: SHALL add 2^(FRAC-1) to the product before the shift (round half up).
- REQ-031 Macro CORDIC_GAIN_ROUND_EN undefined: SHALL truncate toward negative infinity (arithmetic shift).
- REQ-032 Latency and handshake SHALL be identical in both builds.

Structure
- REQ-033 A shared package cordic_pkg SHALL hold the Q16.16 constants CORDIC_WIDTH=32, CORDIC_FRAC=16 and CORDIC_K_INV=39797, plus the FSM state encoding typedef.
- REQ-034 One sub-module cordic_shift_add_mul SHALL implement a single signed serial multiplier (start, done), instantiated twice (x and y).
- REQ-035 The FSM and the z register SHALL live in the top level.

Verification
- REQ-036 Gain check: x_in=107923, y_in=0, z_in=0 -> after 17 cycles x_out=65536 truncated (65537 with ROUND_EN), y_out=0.
- REQ-037 Negative/exact check: x_in=-65536, y_in=65536 -> x_out=-39797, y_out=39797 in both builds.
- REQ-038 Backpressure: out_ready low for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0 throughout; out_ready high -> IDLE next cycle.
- REQ-039 Streaming: in_valid held high, out_ready=1, 3 samples -> accepts spaced 18 cycles apart, results in order, z_out equals each z_in.
- REQ-040 Reset mid-MUL: rst_n low at cycle 8 of MUL -> outputs 0, out_valid never pulses, in_ready=1 after release.
- REQ-041 Input isolation: change x_in during MUL -> result reflects only the captured value.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared Q16.16 constants and FSM state encoding for the CORDIC gain compensation block.
package cordic_pkg;

  localparam int CORDIC_WIDTH = 32;
  localparam int CORDIC_FRAC  = 16;
  localparam int CORDIC_K_INV = 39797;  // 0.607253 in unsigned Q0.16

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } cordic_state_t;

endpackage

// File: rtl/cordic_shift_add_mul.sv
// Signed-by-unsigned serial shift-add multiplier, one multiplier bit per cycle, LSB first.
// start loads the operands; done is high during the last iteration, when product is final.
module cordic_shift_add_mul
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int FRAC  = CORDIC_FRAC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic signed [WIDTH-1:0]       a,
  input  logic        [FRAC-1:0]        b,
  output logic                          done,
  output logic signed [WIDTH+FRAC-1:0]  product
);

  localparam int ACC_W = WIDTH + FRAC;
  localparam int CNT_W = $clog2(FRAC + 1);

  logic signed [ACC_W-1:0] mcand_p0;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] acc_nxt;
  logic        [FRAC-1:0]  mplier_p0;
  logic        [CNT_W-1:0] cnt_p0;
  logic                    run;
  logic                    last;

  // Partial-product add for the current multiplier bit and last-iteration detect.
  always_comb begin
    last    = run && (cnt_p0 == CNT_W'(FRAC - 1));
    acc_nxt = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;
    done    = last;
    product = acc_nxt;
  end

  // Load operands on start, then shift the multiplicand up and the multiplier down each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_p0  <= '0;
      acc_p0    <= '0;
      mplier_p0 <= '0;
      cnt_p0    <= '0;
      run       <= 1'b0;
    end else if (start) begin
      mcand_p0  <= {{FRAC{a[WIDTH-1]}}, a};
      acc_p0    <= '0;
      mplier_p0 <= b;
      cnt_p0    <= '0;
      run       <= 1'b1;
    end else if (run) begin
      acc_p0    <= acc_nxt;
      mcand_p0  <= mcand_p0 <<< 1;
      mplier_p0 <= mplier_p0 >> 1;
      cnt_p0    <= cnt_p0 + CNT_W'(1);
      if (last) run <= 1'b0;
    end
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: scales x and y by K_CONST (Q0.FRAC) with two serial multipliers,
// passes z through a register, and handshakes with valid/ready on both sides.
// Build option: define CORDIC_GAIN_ROUND_EN to round half up instead of truncating.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int WIDTH   = CORDIC_WIDTH,
  parameter int FRAC    = CORDIC_FRAC,
  parameter int K_CONST = CORDIC_K_INV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    busy
);

  localparam int ACC_W = WIDTH + FRAC;
  localparam logic [FRAC-1:0] K_BITS = FRAC'(K_CONST);

`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
`endif

  cordic_state_t           state;
  cordic_state_t           state_nxt;
  logic                    accept;
  logic                    x_done;
  logic                    y_done;
  logic                    mul_done;
  logic signed [ACC_W-1:0] x_prod;
  logic signed [ACC_W-1:0] y_prod;
  logic signed [WIDTH-1:0] z_p0;

  // Drop the fractional bits of a full-precision product (optionally rounding half up first).
  function automatic logic signed [WIDTH-1:0] scale(input logic signed [ACC_W-1:0] p);
`ifdef CORDIC_GAIN_ROUND_EN
    return WIDTH'((p + HALF) >>> FRAC);
`else
    return WIDTH'(p >>> FRAC);
`endif
  endfunction

  cordic_shift_add_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .a       (x_in),
    .b       (K_BITS),
    .done    (x_done),
    .product (x_prod)
  );

  cordic_shift_add_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .a       (y_in),
    .b       (K_BITS),
    .done    (y_done),
    .product (y_prod)
  );

  // Handshake outputs and next-state selection.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == MUL);
    accept    = in_valid && (state == IDLE);
    mul_done  = x_done && y_done;
    case (state)
      IDLE:    if (accept)    state_nxt = MUL;
      MUL:     if (mul_done)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture z on accept; load all three outputs on the final multiply iteration and hold them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_p0  <= '0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      if (accept) z_p0 <= z_in;
      if (state == MUL && mul_done) begin
        x_out <= scale(x_prod);
        y_out <= scale(y_prod);
        z_out <= z_p0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp with a plain-arithmetic reference model.
module tb_cordic_gain_comp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in, y_in, z_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] x_out, y_out, z_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  cordic_gain_comp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: signed product with the gain constant, optional half-up, arithmetic shift by 16.
  function automatic logic [31:0] model(input logic [31:0] v);
    longint p;
    p = longint'($signed(v)) * 64'sd39797;
`ifdef CORDIC_GAIN_ROUND_EN
    p = p + 64'sd32768;
`endif
    return 32'(p >>> 16);
  endfunction

  // Present one sample, let it be accepted, and wait (bounded) for out_valid.
  // lat counts negedges after the accept edge; it equals 60 on timeout.
  task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input bit scramble, output int lat);
    @(negedge clk);
    x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      if (scramble) begin x_in = $urandom; y_in = $urandom; z_in = $urandom; end
      @(negedge clk);
      lat++;
    end
  endtask

  // Consume the held result with a single-cycle out_ready pulse.
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = 32'h1234; y_in = 32'h5678; z_in = 32'h9abc;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (x_out !== 32'd0)    begin errors++; $display("FAIL reset_x_out got %0d want 0", $signed(x_out)); end
    checks++; if (y_out !== 32'd0)    begin errors++; $display("FAIL reset_y_out got %0d want 0", $signed(y_out)); end
    checks++; if (z_out !== 32'd0)    begin errors++; $display("FAIL reset_z_out got %0d want 0", $signed(z_out)); end
    // first accept on the very first edge after release
    x_in = 32'd65536; y_in = 32'd131072; z_in = 32'd77; in_valid = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL first_accept_busy got %b want 1", busy); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL first_accept_in_ready got %b want 0", in_ready); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    checks++; if (lat != 17)          begin errors++; $display("FAIL first_latency got %0d want 17", lat); end
    checks++; if (x_out !== model(32'd65536)) begin errors++; $display("FAIL first_x_out got %0d want %0d", $signed(x_out), $signed(model(32'd65536))); end
    checks++; if (z_out !== 32'd77)   begin errors++; $display("FAIL first_z_out got %0d want 77", $signed(z_out)); end
    release_out();
  endtask

  task automatic test_gain();
    int lat;
    logic [31:0] gain_exp;
`ifdef CORDIC_GAIN_ROUND_EN
    gain_exp = 32'd65537;
`else
    gain_exp = 32'd65536;
`endif
    run_txn(32'd107923, 32'd0, 32'd0, 1'b0, lat);
    checks++; if (lat != 17)           begin errors++; $display("FAIL gain_latency got %0d want 17", lat); end
    checks++; if (x_out !== gain_exp)  begin errors++; $display("FAIL gain_x_out got %0d want %0d", $signed(x_out), gain_exp); end
    checks++; if (y_out !== 32'd0)     begin errors++; $display("FAIL gain_y_out got %0d want 0", $signed(y_out)); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL gain_busy got %b want 0", busy); end
    release_out();
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL gain_after_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL gain_after_in_ready got %b want 1", in_ready); end
    checks++; if (x_out !== gain_exp)  begin errors++; $display("FAIL gain_retain_x got %0d want %0d", $signed(x_out), gain_exp); end
  endtask

  task automatic test_negative();
    int lat;
    run_txn(-32'sd65536, 32'd65536, 32'hdeadbeef, 1'b0, lat);
    checks++; if (x_out !== -32'sd39797)  begin errors++; $display("FAIL neg_x_out got %0d want -39797", $signed(x_out)); end
    checks++; if (y_out !== 32'd39797)    begin errors++; $display("FAIL neg_y_out got %0d want 39797", $signed(y_out)); end
    checks++; if (z_out !== 32'hdeadbeef) begin errors++; $display("FAIL neg_z_out got %h want deadbeef", z_out); end
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] edge_x[6];
    logic [31:0] edge_y[6];
    logic [31:0] x, y, z;
    int lat;
    edge_x = '{32'h7fffffff, 32'h80000000, 32'hffffffff, 32'h00000001, 32'h00008000, 32'hffff8000};
    edge_y = '{32'h80000000, 32'h7fffffff, 32'h00000001, 32'hffffffff, 32'hffff8001, 32'h00007fff};
    for (int i = 0; i < 12; i++) begin
      x = (i < 6) ? edge_x[i] : $urandom;
      y = (i < 6) ? edge_y[i] : $urandom;
      z = $urandom;
      run_txn(x, y, z, 1'b1, lat);
      checks++; if (lat != 17)        begin errors++; $display("FAIL rand_latency[%0d] got %0d want 17", i, lat); end
      checks++; if (x_out !== model(x)) begin errors++; $display("FAIL rand_x_out[%0d] x=%h got %0d want %0d", i, x, $signed(x_out), $signed(model(x))); end
      checks++; if (y_out !== model(y)) begin errors++; $display("FAIL rand_y_out[%0d] y=%h got %0d want %0d", i, y, $signed(y_out), $signed(model(y))); end
      checks++; if (z_out !== z)      begin errors++; $display("FAIL rand_z_out[%0d] got %h want %h", i, z_out, z); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x, y, z;
    int lat;
    x = $urandom; y = $urandom; z = $urandom;
    run_txn(x, y, z, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      checks++; if (x_out !== model(x) || y_out !== model(y) || z_out !== z)
        begin errors++; $display("FAIL bp_hold[%0d] got %h/%h/%h want %h/%h/%h", i, x_out, y_out, z_out, model(x), model(y), z); end
    end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sx[3], sy[3], sz[3];
    int acc_cyc[3];
    int nin, nout, c;
    for (int i = 0; i < 3; i++) begin
      sx[i] = $urandom; sy[i] = $urandom; sz[i] = $urandom; acc_cyc[i] = 0;
    end
    nin = 0; nout = 0; c = 0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    while (nout < 3 && c < 200) begin
      if (out_valid === 1'b1) begin
        checks++; if (x_out !== model(sx[nout]) || y_out !== model(sy[nout]) || z_out !== sz[nout])
          begin errors++; $display("FAIL stream_result[%0d] got %h/%h/%h want %h/%h/%h", nout, x_out, y_out, z_out, model(sx[nout]), model(sy[nout]), sz[nout]); end
        nout++;
      end
      if (in_ready === 1'b1) begin
        if (nin < 3) begin
          x_in = sx[nin]; y_in = sy[nin]; z_in = sz[nin];
          acc_cyc[nin] = c; nin++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (nout != 3) begin errors++; $display("FAIL stream_count got %0d want 3", nout); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 18) begin errors++; $display("FAIL stream_spacing01 got %0d want 18", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (acc_cyc[2] - acc_cyc[1] != 18) begin errors++; $display("FAIL stream_spacing12 got %0d want 18", acc_cyc[2] - acc_cyc[1]); end
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    @(negedge clk);
    x_in = 32'd500000; y_in = 32'd600000; z_in = 32'd42; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (x_out !== 32'd0 || y_out !== 32'd0 || z_out !== 32'd0)
      begin errors++; $display("FAIL midrst_outputs got %h/%h/%h want 0/0/0", x_out, y_out, z_out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin @(negedge clk); if (out_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0)      begin errors++; $display("FAIL midrst_no_pulse got %b want 0", seen); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_isolation();
    int lat;
    run_txn(32'd123456, -32'sd98765, 32'd31337, 1'b1, lat);
    checks++; if (lat != 17)                 begin errors++; $display("FAIL iso_latency got %0d want 17", lat); end
    checks++; if (x_out !== model(32'd123456)) begin errors++; $display("FAIL iso_x_out got %0d want %0d", $signed(x_out), $signed(model(32'd123456))); end
    checks++; if (y_out !== model(-32'sd98765)) begin errors++; $display("FAIL iso_y_out got %0d want %0d", $signed(y_out), $signed(model(-32'sd98765))); end
    checks++; if (z_out !== 32'd31337)       begin errors++; $display("FAIL iso_z_out got %0d want 31337", $signed(z_out)); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_gain();
    test_negative();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_isolation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
